encoder_param_ctrl: RTL and testbench
=====================================

// Module: encoder_param_ctrl
// PURPOSE
//  Consumes rotaryEncoder outputs (user_state_change_stb, clockwise, click, switch). Maintains a bank of
//  NUM_PARAMS user parameters (volume, balance, bass, treble) for the audio path.
//  Detent steps adjust the selected parameter, with acceleration on fast turns.
//  Short press selects the next parameter; long press restores the selected parameter to DEFAULT_VALUE.
// PARAMETERS
//  NUM_PARAMS     4           number of parameters, >=2
//  VALUE_W        8           width of each parameter value
//  MAX_VALUE      100         upper limit of a value; lower limit is 0
//  DEFAULT_VALUE  50          value loaded at reset and on long press
//  ACCEL_WINDOW   2_500_000   clocks; a step arriving sooner than this after the previous step is accelerated
//  ACCEL_STEP     4           step size when accelerated (otherwise 1)
//  LONG_PRESS     50_000_000  clocks the switch must stay low to count as a long press
// PORTS
//  clk                input   1                     system clock
//  reset_n            input   1                     asynchronous, active-low reset
//  state_change_stb   input   1                     1-cycle strobe: click rose or switch fell
//  clockwise          input   1                     rotation direction of the last step
//  click              input   1                     1 = encoder at detent
//  switch             input   1                     debounced push switch; 0 = pressed
//  param_sel          output  $clog2(NUM_PARAMS)    index of the selected parameter
//  param_values       output  NUM_PARAMS*VALUE_W    packed values; param i is at [i*VALUE_W +: VALUE_W]
//  value_update_stb   output  1                     1-cycle pulse when any value changes
//  sel_update_stb     output  1                     1-cycle pulse when param_sel changes
//  at_limit           output  1                     1-cycle pulse when a step was clamped or wrapped
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - all values = DEFAULT_VALUE; param_sel = 0; all strobes = 0
//   - FSM = IDLE; hold counter = 0; interval counter = ACCEL_WINDOW, so the first step is never accelerated
//  Event decode (only on state_change_stb=1)
//   - press: switch==0
//   - otherwise step: click==1
//   - if both are true in the same cycle, the press wins and the step is discarded
//  FSM
//   - IDLE
//       press  -> PRESSED, hold counter cleared
//       step   -> step is applied
//   - PRESSED: hold counter increments every clock; steps are ignored
//       switch==1 before the count reaches LONG_PRESS-1
//           -> param_sel = (param_sel+1) wraps NUM_PARAMS-1 to 0; sel_update_stb; -> IDLE
//       count reaches LONG_PRESS-1 with switch==0
//           -> selected value = DEFAULT_VALUE; value_update_stb only if the value changed; -> HELD
//   - HELD: steps are ignored
//       switch==1 -> IDLE; param_sel unchanged
//  Step
//   - interval counter increments every clock and saturates at ACCEL_WINDOW
//   - step size = ACCEL_STEP if counter < ACCEL_WINDOW, else 1
//   - the counter clears on every applied step
//   - sum/difference computed in VALUE_W+1 bits, so no overflow
//   - cw: add, clamp at MAX_VALUE; ccw: subtract, clamp at 0
//   - at_limit pulses when clamped, including a step taken while already at the limit
//  Latency
//   - value and strobes update 1 clock after state_change_stb (or after the release / hold-expiry cycle)
//   - value_update_stb is not asserted when the value did not change
//   - strobes never last more than 1 cycle
//  Reset mid-press restores all reset values; a pending press is discarded.
// CONFIGURATION
//  ENC_CTRL_WRAP_EN defined
//   - cw past MAX_VALUE wraps: (v+step) mod (MAX_VALUE+1)
//   - ccw below 0 wraps: v-step+MAX_VALUE+1
//   - at_limit pulses on every wrap
//   - value_update_stb is always asserted on a step
//  ENC_CTRL_WRAP_EN undefined
//   - saturating behaviour as above
// TESTING (bench overrides ACCEL_WINDOW=100, LONG_PRESS=1000, MAX_VALUE=100, DEFAULT_VALUE=50)
//  1. reset_n low mid-run -> all values 50, param_sel 0, all strobes 0 on the next edge
//  2. cw steps 200 clocks apart x3
//       -> value0 51, 52, 53; each value_update_stb 1 cycle long, 1 clock after its strobe
//  3. cw step then a 2nd cw step 10 clocks later -> value0 51 then 55; ccw 10 clocks later -> 51
//  4. value0=98, accelerated cw step
//       - saturating: -> 100 with at_limit pulse; a further step gives at_limit and no value_update_stb
//       - with ENC_CTRL_WRAP_EN: -> 1 with at_limit pulse
//  5. four short presses (switch low for 200 clocks each)
//       -> param_sel 1,2,3,0; sel_update_stb per release; values unchanged
//  6. param_sel=2, value 70; switch held low 1500 clocks with cw steps during the hold
//       -> value2 50 after 1000 clocks; steps ignored; after release param_sel still 2

Source files
------------

// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder parameter bank: detent steps adjust the selected value with acceleration,
// short press selects the next parameter, long press restores the default. Wrap mode: ENC_CTRL_WRAP_EN.
module encoder_param_ctrl #(
  parameter int NUM_PARAMS    = 4,
  parameter int VALUE_W       = 8,
  parameter int MAX_VALUE     = 100,
  parameter int DEFAULT_VALUE = 50,
  parameter int ACCEL_WINDOW  = 2_500_000,
  parameter int ACCEL_STEP    = 4,
  parameter int LONG_PRESS    = 50_000_000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              state_change_stb,
  input  logic                              clockwise,
  input  logic                              click,
  input  logic                              switch,
  output logic [$clog2(NUM_PARAMS)-1:0]     param_sel,
  output logic [NUM_PARAMS*VALUE_W-1:0]     param_values,
  output logic                              value_update_stb,
  output logic                              sel_update_stb,
  output logic                              at_limit
);

  localparam int SEL_W = $clog2(NUM_PARAMS);
  localparam int IW    = $clog2(ACCEL_WINDOW + 1);
  localparam int HW    = $clog2(LONG_PRESS);

  typedef logic [VALUE_W-1:0] val_t;
  typedef logic [VALUE_W:0]   ext_t;
  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [IW-1:0]      intv_t;
  typedef logic [HW-1:0]      hold_t;

  localparam ext_t  MAXV      = ext_t'(MAX_VALUE);
  localparam val_t  DEFV      = val_t'(DEFAULT_VALUE);
  localparam sel_t  LAST_SEL  = sel_t'(NUM_PARAMS - 1);
  localparam intv_t WIN       = intv_t'(ACCEL_WINDOW);
  localparam hold_t HOLD_LAST = hold_t'(LONG_PRESS - 1);

`ifdef ENC_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_e;

  state_e state_q, state_d;
  hold_t  hold_q, hold_d;
  intv_t  intv_q, intv_d;
  sel_t   sel_q, sel_d;
  val_t   vals_q [NUM_PARAMS];
  val_t   vals_d [NUM_PARAMS];
  logic   vstb_q, vstb_d, sstb_q, sstb_d, lim_q, lim_d;

  logic   press_ev, step_ev, clamp;
  ext_t   cur, step_sz, sum, diff, nxt;

  // A press wins over a step decoded from the same strobe.
  assign press_ev = state_change_stb & ~switch;
  assign step_ev  = state_change_stb & click & switch;

  always_comb begin
    cur     = ext_t'(vals_q[sel_q]);
    step_sz = (intv_q < WIN) ? ext_t'(ACCEL_STEP) : ext_t'(1);
    sum     = cur + step_sz;
    diff    = cur - step_sz;
    clamp   = 1'b0;
    nxt     = sum;
    if (clockwise) begin
      if (sum > MAXV) begin
        clamp = 1'b1;
        nxt   = WRAP ? sum - MAXV - ext_t'(1) : MAXV;
      end
    end else begin
      nxt = diff;
      // diff has wrapped modulo 2^(VALUE_W+1); adding MAX+1 lands on the wrapped value.
      if (cur < step_sz) begin
        clamp = 1'b1;
        nxt   = WRAP ? diff + MAXV + ext_t'(1) : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    intv_d  = (intv_q == WIN) ? intv_q : intv_q + intv_t'(1);
    sel_d   = sel_q;
    vals_d  = vals_q;
    vstb_d  = 1'b0;
    sstb_d  = 1'b0;
    lim_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_ev) begin
          state_d = S_PRESSED;
          hold_d  = '0;
        end else if (step_ev) begin
          vals_d[sel_q] = nxt[VALUE_W-1:0];
          intv_d        = '0;
          lim_d         = clamp;
          vstb_d        = WRAP ? 1'b1 : (nxt != cur);
        end
      end
      S_PRESSED: begin
        if (switch) begin
          sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + sel_t'(1);
          sstb_d  = 1'b1;
          state_d = S_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          vals_d[sel_q] = DEFV;
          vstb_d        = (vals_q[sel_q] != DEFV);
          state_d       = S_HELD;
        end else begin
          hold_d = hold_q + hold_t'(1);
        end
      end
      S_HELD: begin
        if (switch) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      intv_q  <= WIN;
      sel_q   <= '0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) vals_q[i] <= DEFV;
      vstb_q  <= 1'b0;
      sstb_q  <= 1'b0;
      lim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      intv_q  <= intv_d;
      sel_q   <= sel_d;
      vals_q  <= vals_d;
      vstb_q  <= vstb_d;
      sstb_q  <= sstb_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    param_values = '0;
    for (int unsigned i = 0; i < NUM_PARAMS; i++)
      param_values[i*VALUE_W +: VALUE_W] = vals_q[i];
  end

  assign param_sel        = sel_q;
  assign value_update_stb = vstb_q;
  assign sel_update_stb   = sstb_q;
  assign at_limit         = lim_q;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Directed self-checking bench for encoder_param_ctrl (ACCEL_WINDOW=100, LONG_PRESS=1000).
module tb_encoder_param_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        state_change_stb, clockwise, click, switch;
  logic [1:0]  param_sel;
  logic [31:0] param_values;
  logic        value_update_stb, sel_update_stb, at_limit;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  encoder_param_ctrl #(
    .NUM_PARAMS(4), .VALUE_W(8), .MAX_VALUE(100), .DEFAULT_VALUE(50),
    .ACCEL_WINDOW(100), .ACCEL_STEP(4), .LONG_PRESS(1000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .state_change_stb(state_change_stb),
    .clockwise(clockwise), .click(click), .switch(switch),
    .param_sel(param_sel), .param_values(param_values),
    .value_update_stb(value_update_stb), .sel_update_stb(sel_update_stb),
    .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pv(input int unsigned i);
    return 32'(param_values[i*8 +: 8]);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge after the strobe was captured, so registered results are visible.
  task automatic step(input logic cw);
    @(negedge clk);
    state_change_stb = 1'b1; clockwise = cw; click = 1'b1;
    @(negedge clk);
    state_change_stb = 1'b0; click = 1'b0;
  endtask

  task automatic step_chk(input string tag, input logic cw, input int unsigned idx,
                          input int v, input logic lim, input logic vstb);
    step(cw);
    check({tag, "_val"}, pv(idx), 32'(v));
    check({tag, "_lim"}, 32'(at_limit), 32'(lim));
    check({tag, "_vstb"}, 32'(value_update_stb), 32'(vstb));
  endtask

  task automatic short_press(input int hold);
    @(negedge clk);
    state_change_stb = 1'b1; switch = 1'b0; click = 1'b0;
    @(negedge clk);
    state_change_stb = 1'b0;
    wait_clks(hold);
    switch = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hit_at, vpulses, spulses;
    reset_n = 1'b0; state_change_stb = 1'b0; clockwise = 1'b0; click = 1'b0; switch = 1'b1;
    wait_clks(3);
    for (int i = 0; i < 4; i++) check("rst_val", pv(i), 32'd50);
    check("rst_sel", 32'(param_sel), 32'd0);
    check("rst_stb", {29'd0, value_update_stb, sel_update_stb, at_limit}, 32'd0);
    reset_n = 1'b1;

    // slow steps: size 1, one-cycle update strobe
    for (int k = 1; k <= 3; k++) begin
      wait_clks(200);
      step_chk("slow", 1'b1, 0, 50 + k, 1'b0, 1'b1);
      @(negedge clk);
      check("slow_vstb_width", 32'(value_update_stb), 32'd0);
    end

    // acceleration
    wait_clks(200);
    step_chk("acc_first", 1'b1, 0, 54, 1'b0, 1'b1);
    wait_clks(9);
    step_chk("acc_cw", 1'b1, 0, 58, 1'b0, 1'b1);
    wait_clks(9);
    step_chk("acc_ccw", 1'b0, 0, 54, 1'b0, 1'b1);

    for (int k = 0; k < 11; k++) begin
      wait_clks(3);
      step(1'b1);
    end
    check("to98", pv(0), 32'd98);
    wait_clks(3);
`ifdef ENC_CTRL_WRAP_EN
    step_chk("wrap_cw", 1'b1, 0, 1, 1'b1, 1'b1);
    wait_clks(3);
    step_chk("wrap_cw2", 1'b1, 0, 5, 1'b0, 1'b1);
    wait_clks(3);
    step_chk("wrap_ccw", 1'b0, 0, 1, 1'b0, 1'b1);
    wait_clks(3);
    step_chk("wrap_ccw2", 1'b0, 0, 98, 1'b1, 1'b1);
`else
    step_chk("sat_hi", 1'b1, 0, 100, 1'b1, 1'b1);
    wait_clks(3);
    step_chk("sat_hi_again", 1'b1, 0, 100, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) begin
      wait_clks(3);
      step(1'b0);
    end
    check("to0", pv(0), 32'd0);
    wait_clks(3);
    step_chk("sat_lo", 1'b0, 0, 0, 1'b1, 1'b0);
`endif

    // short presses cycle the selection
    for (int k = 1; k <= 4; k++) begin
      short_press(200);
      check("sp_sel", 32'(param_sel), 32'(k % 4));
      check("sp_sstb", 32'(sel_update_stb), 32'd1);
      check("sp_vals", {8'd0, param_values[31:8]}, {8'd0, 8'd50, 8'd50, 8'd50});
      @(negedge clk);
      check("sp_sstb_width", 32'(sel_update_stb), 32'd0);
    end

    // long press on param 2 restores the default; steps during the hold are ignored
    short_press(20);
    short_press(20);
    check("lp_sel", 32'(param_sel), 32'd2);
    for (int k = 0; k < 20; k++) begin
      wait_clks(110);
      step(1'b1);
    end
    check("lp_pre", pv(2), 32'd70);
    @(negedge clk);
    state_change_stb = 1'b1; switch = 1'b0;
    @(negedge clk);
    state_change_stb = 1'b0;
    hit_at = -1; vpulses = 0; spulses = 0;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      state_change_stb = 1'b0; click = 1'b0;
      if (value_update_stb) begin
        vpulses++;
        if (hit_at < 0) hit_at = i;
      end
      if (sel_update_stb) spulses++;
      if (i % 150 == 0) begin
        state_change_stb = 1'b1; click = 1'b1; clockwise = 1'b1;
      end
    end
    state_change_stb = 1'b0; click = 1'b0;
    check("lp_latency", 32'(hit_at), 32'd1000);
    check("lp_vpulses", 32'(vpulses), 32'd1);
    check("lp_val", pv(2), 32'd50);
    check("lp_no_sstb", 32'(spulses), 32'd0);
    switch = 1'b1;
    @(negedge clk);
    check("lp_rel_sel", 32'(param_sel), 32'd2);
    check("lp_rel_sstb", 32'(sel_update_stb), 32'd0);

    // reset mid-press discards the pending press
    @(negedge clk);
    state_change_stb = 1'b1; switch = 1'b0;
    @(negedge clk);
    state_change_stb = 1'b0;
    wait_clks(50);
    reset_n = 1'b0;
    #1;
    check("mid_rst_v0", pv(0), 32'd50);
    check("mid_rst_v2", pv(2), 32'd50);
    check("mid_rst_sel", 32'(param_sel), 32'd0);
    check("mid_rst_stb", {29'd0, value_update_stb, sel_update_stb, at_limit}, 32'd0);
    wait_clks(2);
    switch = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    spulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sel_update_stb) spulses++;
    end
    check("post_rst_sstb", 32'(spulses), 32'd0);
    check("post_rst_sel", 32'(param_sel), 32'd0);
    step_chk("post_rst_step", 1'b1, 0, 51, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
